// File: rtl/jpeg_pkg.sv
// rtl/jpeg_pkg.sv - shared constants, coefficient type and zigzag index map
package jpeg_pkg;

    localparam int DW = 8;
    localparam int N  = 8;

    typedef logic [DW-1:0] coef_t;

    // Entry [row*8+col] is the zigzag position of natural-order sample (row, col).
    localparam logic [5:0] ZZ_LUT [64] = '{
        6'd0,  6'd1,  6'd5,  6'd6,  6'd14, 6'd15, 6'd27, 6'd28,
        6'd2,  6'd4,  6'd7,  6'd13, 6'd16, 6'd26, 6'd29, 6'd42,
        6'd3,  6'd8,  6'd12, 6'd17, 6'd25, 6'd30, 6'd41, 6'd43,
        6'd9,  6'd11, 6'd18, 6'd24, 6'd31, 6'd40, 6'd44, 6'd53,
        6'd10, 6'd19, 6'd23, 6'd32, 6'd39, 6'd45, 6'd52, 6'd54,
        6'd20, 6'd22, 6'd33, 6'd38, 6'd46, 6'd51, 6'd55, 6'd60,
        6'd21, 6'd34, 6'd37, 6'd47, 6'd50, 6'd56, 6'd59, 6'd61,
        6'd35, 6'd36, 6'd48, 6'd49, 6'd57, 6'd58, 6'd62, 6'd63
    };

    function automatic logic [5:0] zz_idx(input logic [2:0] row, input logic [2:0] col);
        return ZZ_LUT[{row, col}];
    endfunction

endpackage

// File: rtl/zigzag_seq_if.sv
// rtl/zigzag_seq_if.sv - row input and reordered block output handshakes
interface zigzag_seq_if;
    import jpeg_pkg::*;

    logic                  in_valid;
    logic                  in_ready;
    logic [N*DW-1:0]       in_row;
    logic                  in_sob;
    logic                  out_valid;
    logic                  out_ready;
    logic [N*N*DW-1:0]     out_block;
    logic                  resync;

    modport master (
        output in_valid, in_row, in_sob, out_ready,
        input  in_ready, out_valid, out_block, resync
    );

    modport slave (
        input  in_valid, in_row, in_sob, out_ready,
        output in_ready, out_valid, out_block, resync
    );

endinterface

// File: rtl/zigzag_bank.sv
// rtl/zigzag_bank.sv - 64-coefficient bank, one row scattered per write
module zigzag_bank
    import jpeg_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                we_i,
    input  logic [2:0]          row_i,
    input  logic [N*DW-1:0]     data_i,
    output logic [N*N*DW-1:0]   rd_data_o
);

    coef_t mem_q [N*N];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N*N; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i) begin
            for (int c = 0; c < N; c++) begin
                mem_q[zz_idx(row_i, 3'(c))] <= data_i[(N-1-c)*DW +: DW];
            end
        end
    end

    // Zigzag index 0 (DC) lands in the most significant slot.
    always_comb begin
        rd_data_o = '0;
        for (int i = 0; i < N*N; i++) begin
            rd_data_o[(N*N-1-i)*DW +: DW] = mem_q[i];
        end
    end

endmodule

// File: rtl/zigzag_seq.sv
// rtl/zigzag_seq.sv - ping-pong zigzag reorder sequencer between quantizer and coder
module zigzag_seq
    import jpeg_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    zigzag_seq_if.slave bus
);

    logic [2:0] row_cnt_q, row_cnt_d;
    logic       wb_q, wb_d;
    logic       rb_q, rb_d;
    logic [1:0] full_q, full_d;
    logic       resync_q, resync_d;

    logic       accept;
    logic       drain;
    logic [2:0] row_sel;
    logic [1:0] bank_we;
    logic [N*N*DW-1:0] rd0, rd1;

    always_comb begin
        row_cnt_d = row_cnt_q;
        wb_d      = wb_q;
        rb_d      = rb_q;
        full_d    = full_q;
        resync_d  = 1'b0;
        bank_we   = 2'b00;

        accept  = bus.in_valid && !full_q[wb_q];
        drain   = full_q[rb_q] && bus.out_ready;
        row_sel = bus.in_sob ? 3'd0 : row_cnt_q;

        if (drain) begin
            full_d[rb_q] = 1'b0;
            rb_d         = !rb_q;
        end

        // A completing bank is never the draining one: completion needs full[wb]=0.
        if (accept) begin
            bank_we[wb_q] = 1'b1;
            row_cnt_d     = row_sel + 3'd1;
            resync_d      = bus.in_sob && (row_cnt_q != 3'd0);
            if (row_sel == 3'd7) begin
                full_d[wb_q] = 1'b1;
                wb_d         = !wb_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_cnt_q <= '0;
            wb_q      <= 1'b0;
            rb_q      <= 1'b0;
            full_q    <= 2'b00;
            resync_q  <= 1'b0;
        end else begin
            row_cnt_q <= row_cnt_d;
            wb_q      <= wb_d;
            rb_q      <= rb_d;
            full_q    <= full_d;
            resync_q  <= resync_d;
        end
    end

    zigzag_bank u_bank0 (
        .clk       (clk),
        .rst_n     (rst_n),
        .we_i      (bank_we[0]),
        .row_i     (row_sel),
        .data_i    (bus.in_row),
        .rd_data_o (rd0)
    );

    zigzag_bank u_bank1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .we_i      (bank_we[1]),
        .row_i     (row_sel),
        .data_i    (bus.in_row),
        .rd_data_o (rd1)
    );

    assign bus.in_ready  = !full_q[wb_q];
    assign bus.out_valid = full_q[rb_q];
    assign bus.out_block = rb_q ? rd1 : rd0;
    assign bus.resync    = resync_q;

endmodule
